// File: rtl/bits_pkg.sv
// Shared constants for the bit-packer / bit-extractor FIFO path.
package bits_pkg;

    localparam int WORD_W  = 32;
    localparam int FIELD_W = 15;
    localparam int LEN_W   = 4;
    localparam int ACC_W   = WORD_W + FIELD_W;
    localparam int CNT_W   = 6;

    // Field lengths beyond FIELD_W are not legal; treat them as FIELD_W.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (32'(len) > FIELD_W) begin
            return LEN_W'(FIELD_W);
        end
        return len;
    endfunction

endpackage

// File: rtl/bits_pack_align.sv
// Masks a right-justified field to its length and places it directly below
// the cnt bits already held in the left-justified accumulator.
module bits_pack_align
    import bits_pkg::*;
(
    input  logic [FIELD_W-1:0] data,
    input  logic [LEN_W-1:0]   len,
    input  logic [CNT_W-1:0]   cnt,
    output logic [ACC_W-1:0]   aligned
);

    logic [FIELD_W-1:0] mask;
    logic [FIELD_W-1:0] field;
    logic [CNT_W-1:0]   shamt;

    // Field MSB lands at accumulator bit ACC_W-1-cnt; only meaningful while cnt < WORD_W.
    always_comb begin
        mask    = FIELD_W'((32'd1 << len) - 32'd1);
        field   = data & mask;
        shamt   = CNT_W'(ACC_W) - cnt - CNT_W'(len);
        aligned = ACC_W'(field) << shamt;
    end

endmodule

// File: rtl/bits_packer.sv
// Packs 1..15-bit fields MSB-first into 32-bit words with downstream
// backpressure and a zero-padding end-of-stream flush.
module bits_packer
    import bits_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               pushin,
    input  logic [LEN_W-1:0]   lenin,
    input  logic [FIELD_W-1:0] datain,
    input  logic               flushin,
    input  logic               fullin,
    output logic               readyout,
    output logic               pushout,
    output logic [WORD_W-1:0]  dataout,
    output logic               lastout
);

    localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WORD_W);

    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic              flush_pend;

    logic [LEN_W-1:0]  len_eff;
    logic              take;
    logic              flush_take;
    logic [ACC_W-1:0]  aligned;
    logic [ACC_W-1:0]  acc_app;
    logic [CNT_W-1:0]  ncnt;

    logic [ACC_W-1:0]  acc_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              fp_nxt;
    logic              push_nxt;
    logic              last_nxt;
    logic [WORD_W-1:0] data_nxt;

    assign readyout   = (cnt < WORD_CNT) && !flush_pend;
    assign len_eff    = clamp_len(lenin);
    assign take       = pushin && readyout && (len_eff != '0);
    assign flush_take = flushin && readyout;

    bits_pack_align u_align (
        .data    (datain),
        .len     (len_eff),
        .cnt     (cnt),
        .aligned (aligned)
    );

    // Append step, then decide between emitting a full word, a flush word, or holding.
    always_comb begin
        acc_app  = take ? (acc | aligned) : acc;
        ncnt     = cnt + (take ? CNT_W'(len_eff) : '0);

        acc_nxt  = acc_app;
        cnt_nxt  = ncnt;
        fp_nxt   = flush_pend | flush_take;
        push_nxt = 1'b0;
        last_nxt = 1'b0;
        data_nxt = dataout;

        if (ncnt >= WORD_CNT) begin
            // A full word always goes out before any pending flush remainder.
            if (!fullin) begin
                push_nxt = 1'b1;
                data_nxt = acc_app[ACC_W-1 -: WORD_W];
                acc_nxt  = acc_app << WORD_W;
                cnt_nxt  = ncnt - WORD_CNT;
            end
        end else if (flush_pend) begin
            // No append can occur while flush_pend is set, so ncnt equals cnt here.
            if (cnt == '0) begin
                fp_nxt = 1'b0;
            end else if (!fullin) begin
                push_nxt = 1'b1;
                last_nxt = 1'b1;
                data_nxt = acc[ACC_W-1 -: WORD_W];
                acc_nxt  = '0;
                cnt_nxt  = '0;
                fp_nxt   = 1'b0;
            end
        end
    end

    // State and output registers; active-low reset discards any buffered bits.
    always_ff @(posedge clock) begin
        if (!reset) begin
            acc        <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
            pushout    <= 1'b0;
            dataout    <= '0;
            lastout    <= 1'b0;
        end else begin
            acc        <= acc_nxt;
            cnt        <= cnt_nxt;
            flush_pend <= fp_nxt;
            pushout    <= push_nxt;
            dataout    <= data_nxt;
            lastout    <= last_nxt;
        end
    end

endmodule

// File: tb/tb_bits_packer.sv
// Self-checking bench for bits_packer: directed scenarios plus a randomized
// run checked against a bit-queue reference model.
`timescale 1ns/1ps
module tb_bits_packer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        pushin = 1'b0;
    logic [3:0]  lenin = '0;
    logic [14:0] datain = '0;
    logic        flushin = 1'b0;
    logic        fullin = 1'b0;
    logic        readyout;
    logic        pushout;
    logic [31:0] dataout;
    logic        lastout;

    int n_cmp = 0;
    int n_err = 0;

    logic [32:0] obs_q[$];
    logic [32:0] exp_q[$];
    bit          mbits[$];

    bits_packer dut (
        .clock    (clock),
        .reset    (reset),
        .pushin   (pushin),
        .lenin    (lenin),
        .datain   (datain),
        .flushin  (flushin),
        .fullin   (fullin),
        .readyout (readyout),
        .pushout  (pushout),
        .dataout  (dataout),
        .lastout  (lastout)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
        if (pushout === 1'b1) obs_q.push_back({lastout, dataout});
    endtask

    task automatic idle();
        pushin = 1'b0; lenin = '0; datain = '0; flushin = 1'b0; fullin = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    // Reference model: a plain queue of bits in arrival order.
    function automatic void model_full();
        logic [31:0] w;
        while (mbits.size() >= 32) begin
            for (int b = 31; b >= 0; b--) w[b] = mbits.pop_front();
            exp_q.push_back({1'b0, w});
        end
    endfunction

    function automatic void model_push(int len, logic [14:0] d);
        for (int b = len - 1; b >= 0; b--) mbits.push_back(d[b]);
        model_full();
    endfunction

    function automatic void model_flush();
        logic [31:0] w;
        model_full();
        if (mbits.size() > 0) begin
            w = '0;
            for (int b = 31; b >= 0; b--) if (mbits.size() > 0) w[b] = mbits.pop_front();
            exp_q.push_back({1'b1, w});
        end
    endfunction

    task automatic test_reset();
        idle();
        reset = 1'b0;
        step();
        step();
        n_cmp++; if (pushout !== 1'b0) begin n_err++; $display("FAIL reset_pushout: got %b expected 0", pushout); end
        n_cmp++; if (dataout !== 32'h0) begin n_err++; $display("FAIL reset_dataout: got %h expected 00000000", dataout); end
        n_cmp++; if (lastout !== 1'b0) begin n_err++; $display("FAIL reset_lastout: got %b expected 0", lastout); end
        n_cmp++; if (readyout !== 1'b1) begin n_err++; $display("FAIL reset_readyout: got %b expected 1", readyout); end
        reset = 1'b1;
    endtask

    task automatic test_four_bytes();
        logic exp_p;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pushin = 1'b1; lenin = 4'd8; datain = 15'h0AB;
            step();
            exp_p = (i == 3);
            n_cmp++; if (pushout !== exp_p) begin n_err++; $display("FAIL bytes_pushout[%0d]: got %b expected %b", i, pushout, exp_p); end
        end
        n_cmp++; if (dataout !== 32'hABABABAB) begin n_err++; $display("FAIL bytes_data: got %h expected ABABABAB", dataout); end
        n_cmp++; if (lastout !== 1'b0) begin n_err++; $display("FAIL bytes_last: got %b expected 0", lastout); end
        idle();
        step();
        n_cmp++; if (pushout !== 1'b0) begin n_err++; $display("FAIL bytes_pulse: got %b expected 0", pushout); end
        n_cmp++; if (readyout !== 1'b1) begin n_err++; $display("FAIL bytes_ready: got %b expected 1", readyout); end
    endtask

    task automatic test_flush_15();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pushin = 1'b1; lenin = 4'd15; datain = 15'h7FFF;
            step();
        end
        n_cmp++; if (pushout !== 1'b1 || dataout !== 32'hFFFFFFFF || lastout !== 1'b0) begin
            n_err++; $display("FAIL f15_word: got p=%b d=%h l=%b expected p=1 d=FFFFFFFF l=0", pushout, dataout, lastout);
        end
        pushin = 1'b0; flushin = 1'b1;
        step();
        flushin = 1'b0;
        n_cmp++; if (pushout !== 1'b0 || readyout !== 1'b0) begin
            n_err++; $display("FAIL f15_pending: got p=%b r=%b expected p=0 r=0", pushout, readyout);
        end
        step();
        n_cmp++; if (pushout !== 1'b1 || dataout !== 32'hFFF80000 || lastout !== 1'b1) begin
            n_err++; $display("FAIL f15_flush: got p=%b d=%h l=%b expected p=1 d=FFF80000 l=1", pushout, dataout, lastout);
        end
        step();
        n_cmp++; if (pushout !== 1'b0 || readyout !== 1'b1) begin
            n_err++; $display("FAIL f15_after: got p=%b r=%b expected p=0 r=1", pushout, readyout);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        fullin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pushin = 1'b1; lenin = 4'd15; datain = 15'h7FFF;
            step();
        end
        pushin = 1'b0;
        n_cmp++; if (pushout !== 1'b0 || readyout !== 1'b0) begin
            n_err++; $display("FAIL bp_hold: got p=%b r=%b expected p=0 r=0", pushout, readyout);
        end
        step();
        n_cmp++; if (pushout !== 1'b0 || readyout !== 1'b0) begin
            n_err++; $display("FAIL bp_hold2: got p=%b r=%b expected p=0 r=0", pushout, readyout);
        end
        fullin = 1'b0;
        step();
        n_cmp++; if (pushout !== 1'b1 || dataout !== 32'hFFFFFFFF || lastout !== 1'b0) begin
            n_err++; $display("FAIL bp_release: got p=%b d=%h l=%b expected p=1 d=FFFFFFFF l=0", pushout, dataout, lastout);
        end
        n_cmp++; if (readyout !== 1'b1) begin n_err++; $display("FAIL bp_ready: got %b expected 1", readyout); end
        flushin = 1'b1;
        step();
        flushin = 1'b0;
        step();
        n_cmp++; if (pushout !== 1'b1 || dataout !== 32'hFFF80000 || lastout !== 1'b1) begin
            n_err++; $display("FAIL bp_flush: got p=%b d=%h l=%b expected p=1 d=FFF80000 l=1", pushout, dataout, lastout);
        end
    endtask

    task automatic test_same_edge();
        logic [14:0] d1, d2;
        logic [31:0] w;
        d1 = 15'h1234; d2 = 15'h2ABC;
        w  = {d1, d2, 2'b01};
        do_reset();
        pushin = 1'b1; lenin = 4'd15; datain = d1; step();
        datain = d2; step();
        lenin = 4'd4; datain = 15'h0005; flushin = 1'b1;
        step();
        idle();
        n_cmp++; if (pushout !== 1'b1 || dataout !== w || lastout !== 1'b0) begin
            n_err++; $display("FAIL same_word: got p=%b d=%h l=%b expected p=1 d=%h l=0", pushout, dataout, lastout, w);
        end
        step();
        n_cmp++; if (pushout !== 1'b1 || dataout !== 32'h40000000 || lastout !== 1'b1) begin
            n_err++; $display("FAIL same_flush: got p=%b d=%h l=%b expected p=1 d=40000000 l=1", pushout, dataout, lastout);
        end
        step();
        n_cmp++; if (pushout !== 1'b0) begin n_err++; $display("FAIL same_after: got %b expected 0", pushout); end
    endtask

    task automatic test_len0_mask();
        logic [31:0] w;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pushin = 1'b1; lenin = 4'd0; datain = 15'($urandom);
            step();
            n_cmp++; if (pushout !== 1'b0 || readyout !== 1'b1) begin
                n_err++; $display("FAIL len0[%0d]: got p=%b r=%b expected p=0 r=1", i, pushout, readyout);
            end
        end
        pushin = 1'b0; flushin = 1'b1;
        step();
        flushin = 1'b0;
        n_cmp++; if (pushout !== 1'b0) begin n_err++; $display("FAIL empty_flush: got %b expected 0", pushout); end
        step();
        n_cmp++; if (pushout !== 1'b0 || readyout !== 1'b1) begin
            n_err++; $display("FAIL empty_flush_done: got p=%b r=%b expected p=0 r=1", pushout, readyout);
        end
        for (int i = 0; i < 32; i++) w[31 - i] = ((i % 3) == 2);
        for (int i = 0; i < 11; i++) begin
            pushin = 1'b1; lenin = 4'd3; datain = 15'h7FF9;
            step();
        end
        pushin = 1'b0;
        n_cmp++; if (pushout !== 1'b1 || dataout !== w) begin
            n_err++; $display("FAIL mask_word: got p=%b d=%h expected p=1 d=%h", pushout, dataout, w);
        end
        flushin = 1'b1; step(); flushin = 1'b0; step();
        n_cmp++; if (pushout !== 1'b1 || dataout !== 32'h80000000 || lastout !== 1'b1) begin
            n_err++; $display("FAIL mask_flush: got p=%b d=%h l=%b expected p=1 d=80000000 l=1", pushout, dataout, lastout);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pushin = 1'b1; lenin = 4'd8; datain = 15'h05A; step();
        end
        lenin = 4'd8; step(); step();
        lenin = 4'd4; datain = 15'h000F; step();
        pushin = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        n_cmp++; if (pushout !== 1'b0 || dataout !== 32'h0 || lastout !== 1'b0 || readyout !== 1'b1) begin
            n_err++; $display("FAIL midreset: got p=%b d=%h l=%b r=%b expected p=0 d=00000000 l=0 r=1", pushout, dataout, lastout, readyout);
        end
        for (int i = 0; i < 4; i++) begin
            pushin = 1'b1; lenin = 4'd8; datain = 15'h0C3; step();
        end
        pushin = 1'b0;
        n_cmp++; if (pushout !== 1'b1 || dataout !== 32'hC3C3C3C3 || lastout !== 1'b0) begin
            n_err++; $display("FAIL midreset_clean: got p=%b d=%h l=%b expected p=1 d=C3C3C3C3 l=0", pushout, dataout, lastout);
        end
    endtask

    task automatic test_random();
        int  n_acc;
        int  waited;
        int  n;
        logic rdy;
        do_reset();
        obs_q.delete(); exp_q.delete(); mbits.delete();
        n_acc = 0;
        for (int c = 0; c < 1500; c++) begin
            pushin  = ($urandom_range(0, 3) != 0);
            lenin   = 4'($urandom_range(0, 15));
            datain  = 15'($urandom);
            fullin  = ($urandom_range(0, 3) == 0);
            flushin = ($urandom_range(0, 40) == 0);
            rdy = readyout;
            if (pushin && rdy && lenin != 4'd0) begin
                model_push(int'(lenin), datain);
                n_acc++;
            end
            if (flushin && rdy) model_flush();
            step();
        end
        idle();
        waited = 0;
        while (readyout !== 1'b1 && waited < 50) begin
            step();
            waited++;
        end
        n_cmp++; if (readyout !== 1'b1) begin n_err++; $display("FAIL rnd_drain_ready: got %b expected 1 within 50 cycles", readyout); end
        flushin = 1'b1;
        model_flush();
        step();
        flushin = 1'b0;
        for (int i = 0; i < 5; i++) step();
        n_cmp++; if (n_acc < 100) begin n_err++; $display("FAIL rnd_progress: got %0d accepted fields expected at least 100", n_acc); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL rnd_count: got %0d words expected %0d", obs_q.size(), exp_q.size());
        end
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL rnd_word[%0d]: got last=%b data=%h expected last=%b data=%h",
                                  i, obs_q[i][32], obs_q[i][31:0], exp_q[i][32], exp_q[i][31:0]);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_four_bytes();
        test_flush_15();
        test_backpressure();
        test_same_edge();
        test_len0_mask();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
